outbox_uart_tx: RTL and testbench

Drain side of the OUTBOX queue. Pops bytes from a ufifo read port (o_empty_n / i_rd / o_data) and serialises them on a UART 8N1 TX line, LSB first. Sits between the OUTBOX ufifo and the board TX pin, and mirrors the push side driven by the CPU. Optionally renders each byte as printable hex text for terminal debug.

---
 rtl/outbox_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_outbox_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/outbox_uart_tx.sv
// Drains the OUTBOX ufifo onto a UART 8N1 TX line, LSB first, with registered outputs.
// Define OUTBOX_UART_TX_HEX_EN to send each byte as three ASCII characters: high hex digit, low hex digit, space.
module outbox_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_empty_n,
  input  logic [7:0]       i_data,
  output logic             o_rd,
  output logic             o_tx,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t           state, state_nxt;
  logic [15:0]      baud, baud_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             tx_nxt, rd_nxt, busy_nxt;
  logic [CNT_W-1:0] sent_nxt;
  logic             bit_end;

`ifdef OUTBOX_UART_TX_HEX_EN
  typedef enum logic [1:0] {
    C_HI,
    C_LO,
    C_SP
  } char_t;

  char_t      chr, chr_nxt;
  logic [7:0] byte_q, byte_nxt;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  endfunction
`endif

  assign bit_end = (baud == BAUD_LAST);

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path through the case infers a latch.
    state_nxt = state;
    baud_nxt  = baud;
    idx_nxt   = idx;
    shift_nxt = shift;
    tx_nxt    = o_tx;
    rd_nxt    = o_rd;
    busy_nxt  = o_busy;
    sent_nxt  = o_sent;
`ifdef OUTBOX_UART_TX_HEX_EN
    chr_nxt   = chr;
    byte_nxt  = byte_q;
`endif

    unique case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (i_empty_n && i_en) begin
          state_nxt = S_POP;
          rd_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end
      end

      S_POP: begin
        rd_nxt    = 1'b0;
        sent_nxt  = o_sent + CNT_W'(1);
        tx_nxt    = 1'b0;
        baud_nxt  = '0;
        idx_nxt   = '0;
        state_nxt = S_START;
`ifdef OUTBOX_UART_TX_HEX_EN
        byte_nxt  = i_data;
        chr_nxt   = C_HI;
        shift_nxt = hex_ascii(i_data[7:4]);
`else
        shift_nxt = i_data;
`endif
      end

      S_START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          idx_nxt   = '0;
          tx_nxt    = shift[0];
          state_nxt = S_DATA;
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
          end else begin
            // The next bit is shift[1] now; shifting keeps it at [0] for the following boundary.
            idx_nxt   = idx + 3'd1;
            tx_nxt    = shift[1];
            shift_nxt = {1'b0, shift[7:1]};
          end
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
`ifdef OUTBOX_UART_TX_HEX_EN
          unique case (chr)
            C_HI: begin
              chr_nxt   = C_LO;
              shift_nxt = hex_ascii(byte_q[3:0]);
              tx_nxt    = 1'b0;
              state_nxt = S_START;
            end
            C_LO: begin
              chr_nxt   = C_SP;
              shift_nxt = 8'h20;
              tx_nxt    = 1'b0;
              state_nxt = S_START;
            end
            default: begin
              busy_nxt  = 1'b0;
              state_nxt = S_IDLE;
            end
          endcase
`else
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
`endif
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      baud   <= '0;
      idx    <= '0;
      shift  <= '0;
      o_tx   <= 1'b1;
      o_rd   <= 1'b0;
      o_busy <= 1'b0;
      o_sent <= '0;
`ifdef OUTBOX_UART_TX_HEX_EN
      chr    <= C_HI;
      byte_q <= '0;
`endif
    end else begin
      state  <= state_nxt;
      baud   <= baud_nxt;
      idx    <= idx_nxt;
      shift  <= shift_nxt;
      o_tx   <= tx_nxt;
      o_rd   <= rd_nxt;
      o_busy <= busy_nxt;
      o_sent <= sent_nxt;
`ifdef OUTBOX_UART_TX_HEX_EN
      chr    <= chr_nxt;
      byte_q <= byte_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_outbox_uart_tx.sv
// Directed bench for outbox_uart_tx at CLKS_PER_BIT=4 with a small FIFO model and a UART frame sampler.
// Build with OUTBOX_UART_TX_HEX_EN defined to exercise the hex-text path instead of the raw-byte path.
module tb_outbox_uart_tx;

  localparam int CPB   = 4;
  localparam int CNT_W = 16;
  localparam int FLEN  = 10 * CPB;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_en = 1'b0;
  logic             i_empty_n = 1'b0;
  logic [7:0]       i_data = 8'h00;
  logic             o_rd;
  logic             o_tx;
  logic             o_busy;
  logic [CNT_W-1:0] o_sent;

  int total = 0;
  int bad   = 0;

  // FIFO model: the bench pushes at wr_ptr, the sampler process pops after the DUT has latched the head.
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic pop_pend = 1'b0;
  logic prev_rd = 1'b0;
  int rd_pulses = 0;
  int rd_long = 0;
  int rd_empty = 0;

  outbox_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_empty_n(i_empty_n),
    .i_data   (i_data),
    .o_rd     (o_rd),
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_sent   (o_sent)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_rd && prev_rd) rd_long++;
    if (o_rd && !prev_rd) rd_pulses++;
    if (o_rd && !i_empty_n) rd_empty++;
    if (pop_pend && rd_ptr != wr_ptr) rd_ptr = rd_ptr + 1;
    pop_pend = o_rd;
    prev_rd = o_rd;
    i_empty_n = (rd_ptr != wr_ptr);
    i_data = (rd_ptr != wr_ptr) ? mem[rd_ptr % 16] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Waits for a start bit, then samples one whole frame on consecutive negedges.
  // gap counts high samples seen before the start bit; ok clears on any framing fault or timeout.
  task automatic recv_frame(input int drop_at, output logic [7:0] b, output int gap,
                            output bit ok, output int busy_lo);
    logic s [0:FLEN-1];
    int t;
    b = 8'h00; gap = 0; ok = 1'b1; busy_lo = 0; t = 0;
    @(negedge i_clk);
    while (o_tx !== 1'b0 && t < 2000) begin
      gap++; t++;
      @(negedge i_clk);
    end
    if (t >= 2000) begin
      ok = 1'b0;
      return;
    end
    s[0] = o_tx;
    if (o_busy !== 1'b1) busy_lo++;
    for (int i = 1; i < FLEN; i++) begin
      @(negedge i_clk);
      if (i == drop_at) i_en = 1'b0;
      s[i] = o_tx;
      if (o_busy !== 1'b1) busy_lo++;
    end
    for (int j = 0; j < 10; j++)
      for (int k = 1; k < CPB; k++)
        if (s[j*CPB+k] !== s[j*CPB]) ok = 1'b0;
    if (s[0] !== 1'b0 || s[9*CPB] !== 1'b1) ok = 1'b0;
    for (int j = 0; j < 8; j++) b[j] = s[(j+1)*CPB];
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [7:0] b;
    int gap, busy_lo, lows, base, bad_cyc;
    bit ok;

    // Reset and empty-FIFO idle
    i_en = 1'b1;
    do_reset();
    check("rst_tx", o_tx, 1);
    check("rst_rd", o_rd, 0);
    check("rst_busy", o_busy, 0);
    check("rst_sent", o_sent, 0);
    bad_cyc = 0;
    repeat (100) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1 || o_rd !== 1'b0 || o_busy !== 1'b0 || o_sent !== '0) bad_cyc++;
    end
    check("idle_bad_cycles", bad_cyc, 0);

`ifdef OUTBOX_UART_TX_HEX_EN
    // 0x3C rendered as "3C "
    base = rd_pulses;
    push(8'h3C);
    recv_frame(-1, b, gap, ok, busy_lo);
    check("hex_hi_ok", ok, 1);
    check("hex_hi_char", b, 8'h33);
    check("hex_hi_busy_lo", busy_lo, 0);
    recv_frame(-1, b, gap, ok, busy_lo);
    check("hex_lo_ok", ok, 1);
    check("hex_lo_char", b, 8'h43);
    check("hex_lo_gap", gap, 0);
    check("hex_lo_busy_lo", busy_lo, 0);
    recv_frame(-1, b, gap, ok, busy_lo);
    check("hex_sp_ok", ok, 1);
    check("hex_sp_char", b, 8'h20);
    check("hex_sp_gap", gap, 0);
    check("hex_sp_busy_lo", busy_lo, 0);
    @(negedge i_clk);
    check("hex_busy_end", o_busy, 0);
    check("hex_rd_pulses", rd_pulses - base, 1);
    check("hex_sent", o_sent, 1);
`else
    // Single byte 0xA5
    base = rd_pulses;
    push(8'hA5);
    recv_frame(-1, b, gap, ok, busy_lo);
    check("a5_ok", ok, 1);
    check("a5_byte", b, 8'hA5);
    check("a5_busy_lo", busy_lo, 0);
    @(negedge i_clk);
    check("a5_busy_end", o_busy, 0);
    check("a5_rd_pulses", rd_pulses - base, 1);
    check("a5_sent", o_sent, 1);

    // Back-to-back 0x00, 0xFF, 0x3C
    do_reset();
    base = rd_pulses;
    i_en = 1'b0;
    push(8'h00); push(8'hFF); push(8'h3C);
    @(negedge i_clk);
    i_en = 1'b1;
    recv_frame(-1, b, gap, ok, busy_lo);
    check("b2b0_ok", ok, 1);
    check("b2b0_byte", b, 8'h00);
    recv_frame(-1, b, gap, ok, busy_lo);
    check("b2b1_ok", ok, 1);
    check("b2b1_byte", b, 8'hFF);
    check("b2b1_gap", gap, 2);
    recv_frame(-1, b, gap, ok, busy_lo);
    check("b2b2_ok", ok, 1);
    check("b2b2_byte", b, 8'h3C);
    check("b2b2_gap", gap, 2);
    count_lows(20, lows);
    check("b2b_tail_lows", lows, 0);
    check("b2b_rd_pulses", rd_pulses - base, 3);
    check("b2b_sent", o_sent, 3);

    // Enable dropped mid-frame with a second byte queued
    do_reset();
    base = rd_pulses;
    i_en = 1'b0;
    push(8'h11); push(8'h22);
    @(negedge i_clk);
    i_en = 1'b1;
    recv_frame(10, b, gap, ok, busy_lo);
    check("en_ok", ok, 1);
    check("en_byte", b, 8'h11);
    count_lows(30, lows);
    check("en_hold_lows", lows, 0);
    check("en_hold_pulses", rd_pulses - base, 1);
    check("en_hold_empty_n", i_empty_n, 1);
    i_en = 1'b1;
    recv_frame(-1, b, gap, ok, busy_lo);
    check("en_resume_ok", ok, 1);
    check("en_resume_byte", b, 8'h22);
    check("en_resume_pulses", rd_pulses - base, 2);
    check("en_resume_sent", o_sent, 2);
`endif

    // Reset 15 cycles into a frame
    do_reset();
    push(8'h5A);
    begin
      int t = 0;
      while (o_tx !== 1'b0 && t < 200) begin
        t++;
        @(negedge i_clk);
      end
      check("mr_start_seen", (t < 200), 1);
    end
    repeat (14) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("mr_tx", o_tx, 1);
    check("mr_busy", o_busy, 0);
    check("mr_sent", o_sent, 0);
    i_rst = 1'b0;
    count_lows(60, lows);
    check("mr_after_lows", lows, 0);
    check("mr_after_sent", o_sent, 0);

    check("rd_width_over_1", rd_long, 0);
    check("rd_while_empty", rd_empty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
